// File: rtl/instrfetch_pkg.sv
// Shared definitions for the instruction-fetch front end: opcodes, FSM states,
// and the slot counter width helper.
package instrfetch_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_HALT  = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD,
    ST_NEXT,
    ST_HALT
  } state_t;

  // HOLD counts down from slot_cycles-3 to 0.
  function automatic int slot_cnt_w(input int slot_cycles);
    return (slot_cycles <= 4) ? 1 : $clog2(slot_cycles - 2);
  endfunction

endpackage

// File: rtl/instrfetch_instrmem.sv
// Instruction memory, DEPTH x 32: one write port, one synchronous read port with
// one-cycle latency; the read register clears on reset, the array does not.
module instrmem #(
  parameter  int DEPTH = 128,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instrfetch.sv
// Fetch front end: one instruction per SLOT_CYCLES-cycle slot, word and newinstr
// valid in the ISSUE cycle; no backpressure, the slot length is fixed.
module instrfetch
  import instrfetch_pkg::*;
#(
  parameter  int IMEM_DEPTH  = 128,
  parameter  int SLOT_CYCLES = 4,
  localparam int AW          = $clog2(IMEM_DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic          eqflag,
  output logic [31:0]   instrword,
  output logic          newinstr,
  output logic [31:0]   pc,
  output logic          halted
);

  localparam int            CW        = slot_cnt_w(SLOT_CYCLES);
  localparam logic [CW-1:0] HOLD_INIT = CW'(SLOT_CYCLES - 3);
  localparam logic [31:0]   PC_LIMIT  = 32'(4 * IMEM_DEPTH);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    rst_sync;
  logic          active;

  logic [31:0]   pc_inc;
  logic [31:0]   br_off;
  logic [31:0]   npc;
  logic [5:0]    opcode;
  logic          to_halt;
  logic          mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;

  // Reset asserts asynchronously but releases two edges later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign active = rst_sync[1];

  always_comb begin
    pc_inc = pc + 32'd4;
    opcode = instrword[31:26];
    br_off = {{14{instrword[15]}}, instrword[15:0], 2'b00};
    npc    = pc_inc;
    case (opcode)
      OP_J:    npc = {pc_inc[31:28], instrword[25:0], 2'b00};
      OP_BEQ:  if (eqflag) npc = pc_inc + br_off;
      default: ;
    endcase
    to_halt = (opcode == OP_HALT) || (npc[1:0] != 2'b00) || (npc >= PC_LIMIT);
  end

  // The word is read on the edge that enters ISSUE, using the PC being loaded.
  assign mem_raddr = (state == ST_NEXT) ? npc[AW+1:2] : pc[AW+1:2];
  assign mem_re    = active && run &&
                     ((state == ST_IDLE) || ((state == ST_NEXT) && !to_halt));
  assign mem_we    = load_we && ((state == ST_IDLE) || (state == ST_HALT));

  instrmem #(.DEPTH(IMEM_DEPTH)) u_instrmem (
    .clock (clock),
    .reset (reset),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (instrword)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      pc       <= '0;
      newinstr <= 1'b0;
      halted   <= 1'b0;
    end else if (active) begin
      newinstr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            state    <= ST_ISSUE;
            newinstr <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state <= ST_HOLD;
          cnt   <= HOLD_INIT;
        end
        ST_HOLD: begin
          if (cnt == '0) state <= ST_NEXT;
          else           cnt   <= cnt - CW'(1);
        end
        ST_NEXT: begin
          if (to_halt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            pc <= npc;
            if (run) begin
              state    <= ST_ISSUE;
              newinstr <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_HALT: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instrfetch.sv
// Scoreboard bench for instrfetch: an ISA-level model predicts each issued
// (pc, word) pair; a monitor checks every newinstr pulse against the queue.
module tb_instrfetch;
  import instrfetch_pkg::*;

  localparam int DEPTH = 128;
  localparam int SLOT  = 4;
  localparam int AW    = 7;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = '0;
  logic          eqflag = 1'b0;
  logic [31:0]   instrword;
  logic          newinstr;
  logic [31:0]   pc;
  logic          halted;

  logic          s_run = 1'b0;
  logic          s_load_we = 1'b0;
  logic [1:0]    s_load_addr = '0;
  logic [31:0]   s_load_data = '0;
  logic          s_eqflag = 1'b0;
  logic [31:0]   s_instrword;
  logic          s_newinstr;
  logic [31:0]   s_pc;
  logic          s_halted;

  instrfetch #(.IMEM_DEPTH(DEPTH), .SLOT_CYCLES(SLOT)) dut (
    .clock(clock), .reset(reset), .run(run), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data), .eqflag(eqflag),
    .instrword(instrword), .newinstr(newinstr), .pc(pc), .halted(halted)
  );

  instrfetch #(.IMEM_DEPTH(4), .SLOT_CYCLES(3)) u_small (
    .clock(clock), .reset(reset), .run(s_run), .load_we(s_load_we),
    .load_addr(s_load_addr), .load_data(s_load_data), .eqflag(s_eqflag),
    .instrword(s_instrword), .newinstr(s_newinstr), .pc(s_pc), .halted(s_halted)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] epc;
    logic [31:0] eword;
    logic        chained;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] mpc = '0;
  bit          mhalted = 1'b0;
  logic [31:0] sw [4];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    if (newinstr === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: pc %h word %h, expected no pulse", pc, instrword);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_pc", pc, mon_e.epc);
        check("pulse_word", instrword, mon_e.eword);
        if (mon_e.chained) check("slot_period", cyc - last_cyc, SLOT);
      end
      last_cyc = cyc;
    end
  end

  // ISA rules: where does the instruction at mpc send fetch next?
  function automatic void model_step(input bit eq, output logic [31:0] nxt, output bit stop);
    logic [31:0] w;
    int          off;
    w    = mem_m[mpc / 4];
    nxt  = mpc + 32'd4;
    stop = 1'b0;
    if (w[31:26] == OP_J)
      nxt = ((mpc + 32'd4) & 32'hF000_0000) | (32'(w[25:0]) * 32'd4);
    else if (w[31:26] == OP_BEQ && eq) begin
      off = $signed(w[15:0]);
      nxt = mpc + 32'd4 + 32'(off * 4);
    end else if (w[31:26] == OP_HALT)
      stop = 1'b1;
    if ((nxt % 4) != 0 || nxt >= 32'(4 * DEPTH)) stop = 1'b1;
  endfunction

  task automatic load(input int addr, input logic [31:0] data, input bit effective);
    @(negedge clock);
    load_we   = 1'b1;
    load_addr = AW'(addr);
    load_data = data;
    @(negedge clock);
    load_we = 1'b0;
    if (effective) mem_m[addr] = data;
  endtask

  task automatic do_reset();
    @(negedge clock);
    run   = 1'b0;
    s_run = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    mpc     = '0;
    mhalted = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_pulse(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < SLOT + 4; c++) begin
      @(negedge clock);
      if (newinstr === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // mode 0: run to halt; 1: drop run after n slots; 2: reset in HOLD after n slots
  task automatic run_prog(input int mode, input int n, input int eq_force);
    bit          eqs[$];
    bit          eq;
    bit          stop;
    bit          ok;
    int          nexp;
    int          limit;
    logic [31:0] nxt;
    exp_t        e;
    nexp  = 0;
    limit = (mode == 0) ? 400 : n;
    while (!mhalted && nexp < limit) begin
      eq = (eq_force < 0) ? 1'($urandom_range(0, 1)) : (eq_force != 0);
      e.epc     = mpc;
      e.eword   = mem_m[mpc / 4];
      e.chained = (nexp > 0);
      exp_q.push_back(e);
      eqs.push_back(eq);
      model_step(eq, nxt, stop);
      if (stop) mhalted = 1'b1;
      else      mpc = nxt;
      nexp++;
    end
    @(negedge clock);
    eqflag = (nexp > 0) ? eqs[0] : 1'b0;
    run    = (nexp > 0);
    for (int k = 0; k < nexp; k++) begin
      wait_pulse(ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL pulse_timeout: slot %0d got no newinstr, expected one", k);
        break;
      end
      eqflag = eqs[k];
      if (k == nexp - 1) run = 1'b0;
    end
    if (mode == 2) begin
      @(posedge clock);
      #1 reset = 1'b0;
      #1;
      check("rst_async_pc", pc, 32'd0);
      check("rst_async_word", instrword, 32'd0);
      check("rst_async_newinstr", 32'(newinstr), 32'd0);
      check("rst_async_halted", 32'(halted), 32'd0);
      exp_q.delete();
      run = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      mpc     = '0;
      mhalted = 1'b0;
    end else begin
      repeat (3 * SLOT) @(negedge clock);
      check("final_halted", 32'(halted), 32'(mhalted));
      check("final_pc", pc, mpc);
      check("queue_drained", exp_q.size(), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    int          r;
    int          tgt;
    bit          ok;
    logic [31:0] w;

    sw[0] = 32'h0022_1820;
    sw[1] = 32'h0022_1822;
    sw[2] = 32'h0043_1024;
    sw[3] = 32'h0064_2825;

    repeat (3) @(negedge clock);
    check("reset_pc", pc, 32'd0);
    check("reset_word", instrword, 32'd0);
    check("reset_newinstr", 32'(newinstr), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    for (int i = 0; i < DEPTH; i++) load(i, {6'd0, 26'(i)}, 1'b1);

    // straight-line, then halt at word 3
    load(0, 32'h0022_1820, 1'b1);
    load(1, 32'h0022_1822, 1'b1);
    load(2, 32'h8C01_0004, 1'b1);
    load(3, 32'hFC00_0000, 1'b1);
    run_prog(0, 0, -1);

    // a load while halted takes effect; halt at word 2
    load(0, 32'h00A5_2820, 1'b1);
    do_reset();
    load(2, 32'hFC00_0000, 1'b1);
    run_prog(0, 0, -1);

    // beq taken / not taken
    do_reset();
    load(1, 32'h1000_0002, 1'b1);
    load(4, 32'hFC00_0000, 1'b1);
    run_prog(0, 0, 1);
    do_reset();
    run_prog(0, 0, 0);

    // j in range, then j out of range
    do_reset();
    load(0, 32'h0800_0010, 1'b1);
    load(16, 32'h0022_1820, 1'b1);
    load(17, 32'hFC00_0000, 1'b1);
    run_prog(0, 0, -1);
    load(17, 32'h0BFF_FFFF, 1'b1);
    do_reset();
    run_prog(0, 0, -1);

    // run dropped mid-slot, then resumed
    do_reset();
    run_prog(1, 1, -1);
    run_prog(0, 0, -1);

    // reset during HOLD, then restart with memory intact
    do_reset();
    run_prog(2, 2, -1);
    run_prog(0, 0, -1);

    // small instance: falls off the end of a 4-word memory
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      s_load_we   = 1'b1;
      s_load_addr = 2'(i);
      s_load_data = sw[i];
    end
    @(negedge clock);
    s_load_we = 1'b0;
    s_run     = 1'b1;
    cnt       = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      s_load_we = 1'b0;
      if (s_newinstr === 1'b1) begin
        check("small_pc", s_pc, 32'(4 * cnt));
        check("small_word", s_instrword, sw[cnt % 4]);
        if (cnt == 0) begin
          s_load_we   = 1'b1;
          s_load_addr = 2'd0;
          s_load_data = 32'hDEAD_BEEF;
        end
        cnt++;
      end
    end
    check("small_pulses", cnt, 32'd4);
    check("small_halted", 32'(s_halted), 32'd1);
    check("small_final_pc", s_pc, 32'd12);
    do_reset();
    s_run = 1'b1;
    ok    = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (s_newinstr === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("small_restart", 32'(ok), 32'd1);
    check("small_readback", s_instrword, sw[0]);
    s_run = 1'b0;

    // random forward-only program so every run terminates
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      w = {OP_RTYPE, 26'($urandom())};
      else if (r < 55) w = {OP_LW, 26'($urandom())};
      else if (r < 75) w = {OP_BEQ, 10'($urandom()), 16'($urandom_range(0, 6))};
      else if (r < 92) begin
        tgt = i + 1 + $urandom_range(0, 8);
        if ($urandom_range(0, 9) == 0) tgt = 32'h03FF_0000;
        w = {OP_J, 26'(tgt)};
      end else         w = {OP_HALT, 26'($urandom())};
      load(i, w, 1'b1);
    end
    for (int t = 0; t < 3; t++) begin
      do_reset();
      run_prog(0, 0, -1);
    end
    do_reset();
    run_prog(1, 5, -1);
    run_prog(0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
